// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: elastic decode->execute register built as a two-entry skid buffer.
// The main entry drives the E outputs. The skid entry catches one instruction when execute stalls.
// Because of the skid entry, ReadyD can come straight from a flop with no path from ReadyE.
module id_ex_skid_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  output logic                 ReadyD,
  input  logic                 RegWriteD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 MemWriteD,
  input  logic [5:0]           ExCtrlD,
  input  logic [5*XLEN+14:0]   DataD,
  input  logic                 FlushE,
  output logic                 ValidE,
  input  logic                 ReadyE,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic [5:0]           ExCtrlE,
  output logic [5*XLEN+14:0]   DataE,
  output logic [CNT_W-1:0]     StallCnt
);

  localparam int DW = 5*XLEN + 15;
  localparam int CW = 10;
  localparam int EW = CW + DW;

  // Encoding chosen so bit0 is "main valid" and bit1 is "skid valid".
  // This lets ValidE and ReadyD be taken directly from flop outputs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [EW-1:0]    entry_in;
  logic             main_valid;
  logic             skid_valid;
  logic             fire_in;
  logic             fire_out;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign ReadyD     = ~skid_valid;
  assign ValidE     = main_valid;

  assign entry_in = {RegWriteD, ResultSrcD, MemWriteD, ExCtrlD, DataD};
  assign fire_in  = ValidD & ~skid_valid;
  assign fire_out = main_valid & ReadyE;

  // Occupancy transitions and entry loads; skid only ever refills main, keeping FIFO order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (fire_in) begin
          state_d = ONE;
          main_d  = entry_in;
        end
      end
      ONE: begin
        if (fire_in && fire_out) begin
          main_d = entry_in;
        end else if (fire_in) begin
          state_d = FULL;
          skid_d  = entry_in;
        end else if (fire_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (fire_out) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (FlushE) begin
      state_d = EMPTY;
    end
  end

  // Stall counter: counts cycles where execute holds a valid entry, and saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !ReadyE && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, payload and counter registers; reset empties the stage and zeroes all payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Bubble gating: side-effecting controls are forced low when the main entry is empty.
  always_comb begin
    RegWriteE  = main_valid & main_q[EW-1];
    ResultSrcE = main_q[EW-2:EW-3];
    MemWriteE  = main_valid & main_q[EW-4];
    ExCtrlE    = {main_q[EW-5:EW-6] & {2{main_valid}}, main_q[EW-7:EW-10]};
    DataE      = main_q[DW-1:0];
    StallCnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: directed test of the ID/EX skid stage.
// The stage is modelled as a bounded two-deep queue and compared against the DUT every cycle.
// Hand-computed literal expectations also pin the key scenarios.
module tb_id_ex_skid_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int DW    = 5*XLEN + 15;
  localparam int EW    = DW + 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ValidD = 1'b0;
  logic             ReadyD;
  logic             RegWriteD = 1'b0;
  logic [1:0]       ResultSrcD = '0;
  logic             MemWriteD = 1'b0;
  logic [5:0]       ExCtrlD = '0;
  logic [DW-1:0]    DataD = '0;
  logic             FlushE = 1'b0;
  logic             ValidE;
  logic             ReadyE = 1'b0;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             MemWriteE;
  logic [5:0]       ExCtrlE;
  logic [DW-1:0]    DataE;
  logic [CNT_W-1:0] StallCnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] mq[$];
  int            m_cnt = 0;
  bit            m_fin;
  bit            m_fout;
  logic [EW-1:0] head;
  bit            hv;

  id_ex_skid_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ValidD(ValidD), .ReadyD(ReadyD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ExCtrlD(ExCtrlD), .DataD(DataD),
    .FlushE(FlushE),
    .ValidE(ValidE), .ReadyE(ReadyE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ExCtrlE(ExCtrlE), .DataE(DataE),
    .StallCnt(StallCnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Distinct payload per instruction; Rd sits in the low five bits
  function automatic logic [DW-1:0] data_of(input int rd);
    logic [4:0] r;
    r = 5'(rd);
    return {32'h1000_0000 + 32'(rd), 32'h2000_0000 + 32'(rd), 32'h0000_3000 + 32'(rd*4),
            32'hFFFF_0000 ^ 32'(rd), 32'h0000_3004 + 32'(rd*4), r + 5'd1, r + 5'd2, r};
  endfunction

  // Control word {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc/ALUControl}
  function automatic logic [9:0] ctrl_of(input int rd);
    logic [3:0] r;
    r = 4'(rd);
    return {~r[0], r[2:1], r[1], r[2], r[3], r};
  endfunction

  task automatic check_output(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then return shortly after the following rising edge
  task automatic apply_stimulus(input bit v, input int rd, input bit fl, input bit re);
    ValidD = v;
    {RegWriteD, ResultSrcD, MemWriteD, ExCtrlD} = ctrl_of(rd);
    DataD  = data_of(rd);
    FlushE = fl;
    ReadyE = re;
    @(posedge clk);
    #2;
  endtask

  // Reference model: in-order queue of at most two instructions plus a saturating stall count
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      m_fin  = ValidD && (mq.size() < 2);
      m_fout = (mq.size() > 0) && ReadyE;
      if ((mq.size() > 0) && !ReadyE && (m_cnt < CNT_MAX)) m_cnt++;
      if (m_fout) void'(mq.pop_front());
      if (FlushE) mq.delete();
      else if (m_fin) mq.push_back({RegWriteD, ResultSrcD, MemWriteD, ExCtrlD, DataD});
    end
  end

  // Cycle-by-cycle comparison of the DUT against the queue model
  always @(posedge clk) begin
    #1;
    if (reset) begin
      hv   = mq.size() > 0;
      head = hv ? mq[0] : '0;
      check_output("cmp_ReadyD", ReadyD, mq.size() < 2);
      check_output("cmp_ValidE", ValidE, hv);
      check_output("cmp_StallCnt", StallCnt, m_cnt);
      check_output("cmp_RegWriteE", RegWriteE, hv & head[EW-1]);
      check_output("cmp_MemWriteE", MemWriteE, hv & head[EW-4]);
      check_output("cmp_JumpBranchE", ExCtrlE[5:4], hv ? head[EW-5:EW-6] : 2'b00);
      if (hv) begin
        check_output("cmp_DataE", DataE, head[DW-1:0]);
        check_output("cmp_ResultSrcE", ResultSrcE, head[EW-2:EW-3]);
        check_output("cmp_ExCtrlLowE", ExCtrlE[3:0], head[EW-7:EW-10]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_ReadyD", ReadyD, 1);
    check_output("rst_ValidE", ValidE, 0);
    check_output("rst_DataE", DataE, 0);
    check_output("rst_StallCnt", StallCnt, 0);
    check_output("rst_ctrl", {RegWriteE, ResultSrcE, MemWriteE, ExCtrlE}, 0);
    #3;
    reset = 1'b1;

    // Stream: one per cycle, one cycle latency
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1, k, 0, 1);
      check_output("stream_rd", DataE[4:0], k);
      check_output("stream_ReadyD", ReadyD, 1);
    end
    apply_stimulus(0, 0, 0, 1);
    check_output("stream_drain", ValidE, 0);

    // Backpressure: 5 in main, 6 in skid, 7 held at decode
    apply_stimulus(1, 5, 0, 0);
    check_output("bp_rd5", DataE[4:0], 5);
    apply_stimulus(1, 6, 0, 0);
    check_output("bp_ReadyD_full", ReadyD, 0);
    for (int k = 0; k < 3; k++) apply_stimulus(1, 7, 0, 0);
    check_output("bp_hold_rd5", DataE[4:0], 5);
    check_output("bp_stall4", StallCnt, 4);
    apply_stimulus(1, 7, 0, 1);
    check_output("bp_rd6", DataE[4:0], 6);
    check_output("bp_ReadyD_back", ReadyD, 1);
    apply_stimulus(1, 7, 0, 1);
    check_output("bp_rd7", DataE[4:0], 7);
    apply_stimulus(0, 0, 0, 1);
    check_output("bp_drain", ValidE, 0);
    check_output("bp_stall_kept", StallCnt, 4);

    // Flush while FULL with a same-cycle incoming instruction
    apply_stimulus(1, 8, 0, 0);
    apply_stimulus(1, 10, 0, 0);
    check_output("fl_full", ReadyD, 0);
    apply_stimulus(1, 9, 1, 0);
    check_output("fl_ValidE", ValidE, 0);
    check_output("fl_gates", {RegWriteE, MemWriteE}, 0);
    check_output("fl_ReadyD", ReadyD, 1);
    check_output("fl_stall6", StallCnt, 6);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(0, 0, 0, 1);
      check_output("fl_no_rd9", ValidE, 0);
    end

    // Bubble gating with stale write-enables in the main entry
    apply_stimulus(1, 14, 0, 1);
    check_output("bub_live", {RegWriteE, MemWriteE, ExCtrlE[5:4]}, 4'b1111);
    apply_stimulus(0, 14, 0, 1);
    check_output("bub_gated", {ValidE, RegWriteE, MemWriteE, ExCtrlE[5:4]}, 0);

    // Asynchronous reset while FULL
    apply_stimulus(1, 2, 0, 0);
    apply_stimulus(1, 6, 0, 0);
    check_output("ar_full", ReadyD, 0);
    check_output("ar_stall7", StallCnt, 7);
    #3;
    reset = 1'b0;
    #1;
    check_output("ar_ValidE", ValidE, 0);
    check_output("ar_ReadyD", ReadyD, 1);
    check_output("ar_StallCnt", StallCnt, 0);
    check_output("ar_DataE", DataE, 0);
    check_output("ar_ctrl", {RegWriteE, ResultSrcE, MemWriteE, ExCtrlE}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1, 3, 0, 1);
    check_output("ar_first_accept", {ValidE, DataE[4:0]}, {1'b1, 5'd3});
    apply_stimulus(0, 0, 0, 1);

    // Stall counter saturation
    apply_stimulus(1, 11, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(0, 0, 0, 0);
      if (i == 10) check_output("sat_10", StallCnt, 10);
    end
    check_output("sat_15", StallCnt, 15);
    check_output("sat_hold_rd11", {ValidE, DataE[4:0]}, {1'b1, 5'd11});
    apply_stimulus(0, 0, 0, 1);
    check_output("sat_drain", ValidE, 0);
    check_output("sat_kept", StallCnt, 15);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
